mul_sched_8x8: RTL

MUL_SCHED_8X8 -- requirements
Module: mul_sched_8x8

---
 rtl/mul_sched_pkg.sv | 12 +
 rtl/rr_pick4.sv | 20 ++
 rtl/top_8x8.sv | 13 +
 rtl/mul_sched_8x8.sv | 109 ++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mul_sched_pkg;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int OPW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first asserted request at or after ptr, wrapping 3->0.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       gnt_vld,
  output logic [1:0] gnt_id
);
  logic [1:0] idx;

  always_comb begin
    gnt_vld = |req;
    gnt_id  = 2'd0;
    idx     = 2'd0;
    // Scan farthest-first so the candidate closest to ptr overwrites the others.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) gnt_id = idx;
    end
  end
endmodule

// File: rtl/top_8x8.sv
// Unsigned 8x8 array multiplier with carry-out of the 17-bit sum.
module top_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod,
  output logic        cout
);
  logic [16:0] full;

  assign full = 17'(a) * 17'(b);
  assign prod = full[15:0];
  assign cout = full[16];
endmodule

// File: rtl/mul_sched_8x8.sv
// Four requesters share one 8x8 multiplier; round-robin grant, one op in flight, held response.
module mul_sched_8x8
  import mul_sched_pkg::state_t, mul_sched_pkg::IDLE, mul_sched_pkg::CALC,
         mul_sched_pkg::RESP, mul_sched_pkg::OPW;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [15:0]         rsp_prod,
  output logic                rsp_cout,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy,
  output logic [15:0]         op_count
);
  state_t             state_reg, state_next;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [IDW-1:0]     id_reg;
  logic [OPW-1:0]     a_reg, b_reg;
  logic [15:0]        prod_reg;
  logic               cout_reg;
  logic [15:0]        op_count_reg;

  logic [OPW-1:0]     a_slice [NREQ];
  logic [OPW-1:0]     b_slice [NREQ];
  logic               gnt_vld;
  logic [IDW-1:0]     gnt_id;
  logic               grant;
  logic [15:0]        mul_prod;
  logic               mul_cout;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[8*gi +: 8];
    assign b_slice[gi] = req_b[8*gi +: 8];
  end

  rr_pick4 u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  top_8x8 u_mul (
    .a    (a_reg),
    .b    (b_reg),
    .prod (mul_prod),
    .cout (mul_cout)
  );

  // Grant is gated by rst_n so req_ready reads 0 while reset is held.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    grant      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_vld && rst_n) begin
          req_ready[gnt_id] = 1'b1;
          grant             = 1'b1;
          state_next        = CALC;
        end
      end
      CALC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      id_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      prod_reg     <= '0;
      cout_reg     <= 1'b0;
      op_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        a_reg      <= a_slice[gnt_id];
        b_reg      <= b_slice[gnt_id];
        id_reg     <= gnt_id;
        rr_ptr_reg <= gnt_id + 1'b1;
      end
      if (state_reg == CALC) begin
        prod_reg <= mul_prod;
        cout_reg <= mul_cout;
      end
      if (state_reg == RESP && rsp_ready) op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_prod  = prod_reg;
  assign rsp_cout  = cout_reg;
  assign rsp_id    = id_reg;
  assign op_count  = op_count_reg;
endmodule
